// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle PC sequencer with imem fetch handshake, branch resolve and fetch timeout
module branch_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] ir,
  output logic            ir_valid,
  input  logic            halt_in,
  input  logic            is_jmp,
  input  logic            is_cond,
  input  logic            exec_done,
  input  logic            jump,
  input  logic [PC_W-1:0] target,
  output logic            cmp_en,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     instr_count,
  output logic            timeout_err,
  output logic [2:0]      state
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_RESOLVE = 3'd4,
    S_HALTED  = 3'd5
  } state_t;
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_t          r_state, w_state_nx;
  logic [PC_W-1:0] r_pc, w_pc_nx, r_ir, w_ir_nx;
  logic [15:0]     r_cnt, w_cnt_nx;
  logic [WW-1:0]   r_wait, w_wait_nx;
  logic            r_to, w_to_nx;
  logic [PC_W-1:0] w_pc_inc;
  state_t          w_after;
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_after  = run ? S_FETCH : S_IDLE;
  // next-state and datapath updates; retirement bumps the counter and re-samples run
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_ir_nx    = r_ir;
    w_cnt_nx   = r_cnt;
    w_wait_nx  = r_wait;
    w_to_nx    = r_to;
    case (r_state)
      S_IDLE: w_state_nx = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (imem_ack) begin
          w_ir_nx    = imem_rdata;
          w_wait_nx  = '0;
          w_state_nx = S_DECODE;
        end else if (r_wait == WW'(MAX_WAIT - 1)) begin
          w_to_nx    = 1'b1;
          w_wait_nx  = '0;
          w_state_nx = S_HALTED;
        end else begin
          w_wait_nx  = r_wait + WW'(1);
        end
      end
      S_DECODE: w_state_nx = halt_in ? S_HALTED : S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          if (!is_jmp && is_cond) begin
            w_state_nx = S_RESOLVE;
          end else begin
            w_pc_nx    = is_jmp ? target : w_pc_inc;
            w_cnt_nx   = r_cnt + 16'd1;
            w_state_nx = w_after;
          end
        end
      end
      S_RESOLVE: begin
        w_pc_nx    = jump ? target : w_pc_inc;
        w_cnt_nx   = r_cnt + 16'd1;
        w_state_nx = w_after;
      end
      default: w_state_nx = r_state;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_ir    <= w_ir_nx;
      r_cnt   <= w_cnt_nx;
      r_wait  <= w_wait_nx;
      r_to    <= w_to_nx;
    end
  end
  assign imem_req    = r_state == S_FETCH;
  assign imem_addr   = r_pc;
  assign ir          = r_ir;
  assign ir_valid    = r_state == S_DECODE;
  assign cmp_en      = r_state == S_RESOLVE;
  assign pc          = r_pc;
  assign instr_count = r_cnt;
  assign timeout_err = r_to;
  assign state       = r_state;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed phases with an ir_valid-driven scoreboard for the branch sequencer
module tb_branch_sequencer;
  logic        clk = 1'b0, rst_n = 1'b1, run = 1'b0, imem_ack = 1'b0;
  logic        exec_done = 1'b1, jump = 1'b0;
  logic [15:0] target = '0, w0 = '0, w4 = 16'h0004, w100 = 16'h0100;
  logic        imem_req, ir_valid, halt_in, is_jmp, is_cond, cmp_en, timeout_err;
  logic [15:0] imem_addr, imem_rdata, ir, pc, instr_count;
  logic [2:0]  state;
  int          total = 0, bad = 0, n_irv = 0, n_cmp = 0, n_req = 0;
  typedef struct packed {logic [15:0] pc; logic [15:0] ir; logic [15:0] cnt;} exp_t;
  exp_t        q[$];
  always #5 clk = ~clk;
  // small instruction memory: three programmable words, every other address holds a plain op
  assign imem_rdata = imem_addr == 16'h0000 ? w0 :
                      imem_addr == 16'h0004 ? w4 :
                      imem_addr == 16'h0100 ? w100 : {4'h0, imem_addr[11:0]};
  // decoder model: opcode nibble 1=jmp, 2=cond, 3=jmp+cond, F=halt
  assign is_jmp  = ir[15:12] == 4'h1 || ir[15:12] == 4'h3;
  assign is_cond = ir[15:12] == 4'h2 || ir[15:12] == 4'h3;
  assign halt_in = ir[15:12] == 4'hF;
  branch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid),
    .halt_in(halt_in), .is_jmp(is_jmp), .is_cond(is_cond), .exec_done(exec_done),
    .jump(jump), .target(target), .cmp_en(cmp_en), .pc(pc), .instr_count(instr_count),
    .timeout_err(timeout_err), .state(state)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [15:0] p, input logic [15:0] i, input logic [15:0] c);
    q.push_back({p, i, c});
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rst_phase();
    @(posedge clk);
    #1 rst_n = 1'b0;
    n_irv = 0; n_cmp = 0; n_req = 0;
    tick(1);
    rst_n = 1'b1;
  endtask
  // monitor: every decoded instruction is checked against the next expected fetch
  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) n_cmp++;
    if (imem_req) n_req++;
    if (ir_valid) begin
      n_irv++;
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got ir_valid at pc %0h want no decode", pc);
      end else begin
        e = q.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_ir", ir, e.ir);
        chk("sb_cnt", instr_count, e.cnt);
      end
    end
  end
  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", state, 0); chk("rst_pc", pc, 0); chk("rst_cnt", instr_count, 0);
    chk("rst_req", imem_req, 0); chk("rst_to", timeout_err, 0);
    // plain stream then conditional taken at pc 4, then run dropped mid-EXEC
    w4 = 16'h2004; target = 16'h0020; jump = 1'b1; run = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) push(16'(i), 16'(i), 16'(i));
    push(16'h0004, 16'h2004, 4); push(16'h0020, 16'h0020, 5);
    rst_phase();
    tick(1);
    chk("p1_fetch", state, 1); chk("p1_req", imem_req, 1); chk("p1_addr", imem_addr, 0);
    tick(9);
    chk("p1_cnt3", instr_count, 3); chk("p1_pc3", pc, 3); chk("p1_irv3", n_irv, 3);
    tick(6);
    chk("p1_resolve", state, 4); chk("p1_cmp_en", cmp_en, 1);
    tick(1);
    chk("p1_taken_pc", pc, 16'h0020); chk("p1_cmp_off", cmp_en, 0);
    chk("p1_cnt5", instr_count, 5); chk("p1_ncmp", n_cmp, 1);
    tick(2);
    chk("p1_exec", state, 3);
    run = 1'b0; exec_done = 1'b0;
    tick(2);
    chk("p1_exec_hold", state, 3); chk("p1_exec_pc", pc, 16'h0020);
    exec_done = 1'b1;
    tick(1);
    chk("p1_idle", state, 0); chk("p1_idle_pc", pc, 16'h0021); chk("p1_idle_cnt", instr_count, 6);
    tick(2);
    chk("p1_idle_stay", state, 0); chk("p1_idle_req", imem_req, 0);
    // same branch not taken
    jump = 1'b0; run = 1'b1;
    for (int i = 0; i < 4; i++) push(16'(i), 16'(i), 16'(i));
    push(16'h0004, 16'h2004, 4); push(16'h0005, 16'h0005, 5);
    rst_phase();
    tick(16);
    chk("p2_cmp_en", cmp_en, 1);
    tick(1);
    chk("p2_nt_pc", pc, 16'h0005); chk("p2_cnt5", instr_count, 5);
    run = 1'b0;
    tick(3);
    chk("p2_idle", state, 0); chk("p2_pc6", pc, 16'h0006);
    // jmp+cond together takes the jump with no resolve; then HALT ignores run
    w0 = 16'h3000; w4 = 16'h0004; w100 = 16'hF000; target = 16'h0100; jump = 1'b1; run = 1'b1;
    push(16'h0000, 16'h3000, 0); push(16'h0100, 16'hF000, 1);
    rst_phase();
    tick(4);
    chk("p3_pc", pc, 16'h0100); chk("p3_cnt", instr_count, 1); chk("p3_ncmp", n_cmp, 0);
    tick(2);
    chk("p3_halted", state, 5); chk("p3_halt_pc", pc, 16'h0100); chk("p3_halt_cnt", instr_count, 1);
    run = 1'b0; tick(2); run = 1'b1; tick(2);
    chk("p3_halt_stay", state, 5); chk("p3_ncmp_end", n_cmp, 0);
    // jump to FFFF, plain op there wraps pc to 0
    w0 = 16'h1000; w100 = 16'h0100; target = 16'hFFFF;
    push(16'h0000, 16'h1000, 0); push(16'hFFFF, 16'h0FFF, 1); push(16'h0000, 16'h1000, 2);
    rst_phase();
    tick(4);
    chk("p4_jmp_pc", pc, 16'hFFFF);
    tick(3);
    chk("p4_wrap_pc", pc, 16'h0000); chk("p4_cnt", instr_count, 2);
    run = 1'b0;
    tick(3);
    chk("p4_idle", state, 0); chk("p4_pc", pc, 16'hFFFF); chk("p4_cnt3", instr_count, 3);
    // fetch timeout after exactly 8 request cycles
    w0 = 16'h0000; imem_ack = 1'b0; run = 1'b1;
    rst_phase();
    tick(8);
    chk("p5_still_fetch", state, 1); chk("p5_no_to", timeout_err, 0);
    tick(1);
    chk("p5_halted", state, 5); chk("p5_to", timeout_err, 1);
    chk("p5_req_off", imem_req, 0); chk("p5_nreq", n_req, 8);
    tick(3);
    chk("p5_to_sticky", timeout_err, 1);
    // ack on the last allowed cycle wins
    push(16'h0000, 16'h0000, 0);
    rst_phase();
    tick(8);
    chk("p6_fetch", state, 1);
    imem_ack = 1'b1;
    tick(1);
    chk("p6_decode", state, 2); chk("p6_no_to", timeout_err, 0);
    imem_ack = 1'b0; run = 1'b0;
    tick(2);
    chk("p6_idle", state, 0); chk("p6_cnt", instr_count, 1); chk("p6_pc", pc, 1);
    chk("p6_to", timeout_err, 0);
    // asynchronous reset in the middle of a fetch
    run = 1'b1;
    tick(1);
    chk("p7_fetch", state, 1); chk("p7_req", imem_req, 1); chk("p7_addr", imem_addr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("p7_req_drop", imem_req, 0); chk("p7_state", state, 0); chk("p7_pc", pc, 0);
    chk("p7_ir", ir, 0); chk("p7_cnt", instr_count, 0); chk("p7_irv", ir_valid, 0);
    tick(2);
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
